// File: rtl/latch_deser_pkg.sv
// Shared types and defaults for the latch deserializer.
package latch_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } deser_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/deser_bit_counter.sv
// Counts sampled bits within a frame and flags the final bit position.
module deser_bit_counter
  import latch_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  // Bit counter: clear wins over increment so a completed word leaves it at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/latch_deserializer.sv
// Samples the latched serial bit on enabled edges, assembles MSB-first words
// and offers them on a valid/ready handshake with a sticky overrun flag.
module latch_deserializer
  import latch_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d_in,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

  deser_state_t     state;
  deser_state_t     state_nxt;
  logic [WIDTH-1:0] sr;
  logic             last;
  logic             sample;
  logic             complete;
  logic             drop;

  // Append one bit at the LSB end; older bits move toward the MSB.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
    return WIDTH'({s, b});
  endfunction

  // The counter sits at zero outside SHIFT, so 'last' outside SHIFT is only
  // true for single-bit words, where the first sample also completes the word.
  deser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (complete),
    .inc   (sample && !complete),
    .last  (last)
  );

  // Next-state and sample/drop decisions.
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (start && en) begin
          sample    = 1'b1;
          state_nxt = last ? HOLD : SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          sample = 1'b1;
          if (last) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          if (start && en) begin
            sample    = 1'b1;
            state_nxt = last ? HOLD : SHIFT;
          end else begin
            state_nxt = IDLE;
          end
        end else if (start && en) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    complete = sample && last;
  end

  // State register with busy/valid registered alongside it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      valid <= (state_nxt == HOLD);
    end
  end

  // Shift register and output word; d_in is only looked at on sampling edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr       <= '0;
      data_out <= '0;
    end else begin
      if (sample)   sr       <= shift_in(sr, d_in);
      if (complete) data_out <= shift_in(sr, d_in);
    end
  end

  // Sticky overrun: a dropped frame start beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_latch_deserializer.sv
module tb_latch_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, en, d_in, start, ready, clr_ovr;
  logic [W-1:0] data_out;
  logic         valid, busy, overrun;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  latch_deserializer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .d_in     (d_in),
    .start    (start),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .overrun  (overrun),
    .clr_ovr  (clr_ovr)
  );

  always #5 clk = ~clk;

  // Frame-level reference: collect bits into an integer, publish when W arrive.
  bit           m_active, m_valid, m_ovr;
  int           m_n;
  logic [W-1:0] m_acc, m_word;

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_active = 0; m_valid = 0; m_ovr = 0; m_n = 0; m_acc = '0; m_word = '0;
    end else begin
      bit was_valid, begin_frame, set_ovr;
      was_valid   = m_valid;
      begin_frame = 0;
      set_ovr     = was_valid && !ready && start && en;
      if (was_valid && ready) m_valid = 0;
      if (m_active) begin
        if (en) begin
          m_acc = (m_acc << 1) | W'(d_in);
          m_n++;
        end
      end else if (start && en && (!was_valid || ready)) begin
        begin_frame = 1;
      end
      if (begin_frame) begin
        m_active = 1;
        m_acc    = W'(d_in);
        m_n      = 1;
      end
      if (m_active && m_n == W) begin
        m_word   = m_acc;
        m_valid  = 1;
        m_active = 0;
        m_n      = 0;
      end
      if (set_ovr) m_ovr = 1;
      else if (clr_ovr) m_ovr = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_data",    32'(data_out), 32'(m_word));
      check("cyc_valid",   32'(valid),    32'(m_valid));
      check("cyc_busy",    32'(busy),     32'(m_active || m_valid));
      check("cyc_overrun", 32'(overrun),  32'(m_ovr));
    end
  end

  task automatic step(input logic r, input logic e, input logic d, input logic s,
                      input logic rdy, input logic c);
    rst_n = r; en = e; d_in = d; start = s; ready = rdy; clr_ovr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic first_ready);
    for (int i = 0; i < W; i++)
      step(1, 1, w[W-1-i], i == 0, (i == 0) ? first_ready : 1'b0, 0);
  endtask

  initial begin
    rst_n = 0; en = 0; d_in = 0; start = 0; ready = 0; clr_ovr = 0;

    // 1: reset
    step(0, 0, 0, 0, 0, 0);
    chk_on = 1'b1;
    step(0, 1, 1, 1, 1, 0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);

    // start without en is ignored
    step(1, 0, 1, 1, 0, 0);
    check("start_no_en_busy", 32'(busy), 32'h0);

    // 2: contiguous 0xA5
    for (int i = 0; i < W - 1; i++) step(1, 1, W'(8'hA5) >> (W - 1 - i), i == 0, 0, 0);
    check("a5_valid_before_last", 32'(valid), 32'h0);
    check("a5_busy_shift", 32'(busy), 32'h1);
    step(1, 1, 1, 0, 0, 0);
    check("a5_valid", 32'(valid), 32'h1);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_busy", 32'(busy), 32'h1);
    step(1, 0, 0, 0, 1, 0);
    check("a5_accept_valid", 32'(valid), 32'h0);
    check("a5_accept_busy", 32'(busy), 32'h0);

    // 3: 0xA5 with en gaps after bits 2 and 5, plus a stray start mid-frame
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int g = 0; g < 3; g++) step(1, 0, 1'bx, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int g = 0; g < 3; g++) step(1, 0, 1'bx, 0, 0, 0);
    check("gap_valid_early", 32'(valid), 32'h0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check("gap_valid_7", 32'(valid), 32'h0);
    step(1, 1, 1, 0, 0, 0);
    check("gap_valid", 32'(valid), 32'h1);
    check("gap_data", 32'(data_out), 32'hA5);

    // 4: hold, overrun (set beats clr), accept, clear
    for (int h = 0; h < 5; h++) step(1, h[0], 1'b0, 0, 0, 0);
    check("hold_data", 32'(data_out), 32'hA5);
    step(1, 1, 0, 1, 0, 1);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_word", 32'(data_out), 32'hA5);
    check("ovr_valid", 32'(valid), 32'h1);
    step(1, 0, 0, 0, 1, 0);
    check("ovr_accept_valid", 32'(valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);
    step(1, 0, 0, 0, 0, 1);
    check("ovr_clr", 32'(overrun), 32'h0);

    // 5: back-to-back 0x5A then 0x3C starting on the accepting edge
    send_frame(8'h5A, 1'b0);
    check("b2b_first", 32'(data_out), 32'h5A);
    send_frame(8'h3C, 1'b1);
    check("b2b_data", 32'(data_out), 32'h3C);
    check("b2b_valid", 32'(valid), 32'h1);
    step(1, 0, 0, 0, 1, 0);

    // 6: reset mid-frame, then 0xFF
    for (int i = 0; i < 4; i++) step(1, 1, 1, i == 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_data", 32'(data_out), 32'h0);
    send_frame(8'hFF, 1'b0);
    check("ff_data", 32'(data_out), 32'hFF);
    check("ff_valid", 32'(valid), 32'h1);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
